pw_input_cond: RTL and testbench

Input conditioner for the password lock's PMOD inputs. It synchronizes the raw 7-bit password switches and the enter button into the FSM clock domain and debounces them as one coherent 8-bit vector. It then emits a single-cycle `enter_pulse` together with a latched, stable `char_out`. It sits directly upstream of `pw_fsm`, driving its `char_in` and `enter` inputs.

---
 rtl/pw_input_cond.sv | 77 +++++++
 tb/tb_pw_input_cond.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pw_input_cond.sv
// pw_input_cond: synchronizes and debounces {enter_raw, pw_raw} as one vector,
// then emits a single enter_pulse per debounced press with the captured character.
module pw_input_cond #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] pw_raw,
  input  logic       enter_raw,
  output logic [6:0] char_out,
  output logic       enter_pulse,
  output logic       armed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {ARM_WAIT, IDLE, FIRE, HELD} state_t;

  logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
  logic [7:0]    sv, prev_q, prev_d, dv_q, dv_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_valid_q, deb_valid_d, stable, commit;
  logic [6:0]    char_q, char_d;
  state_t        state_q, state_d;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], {enter_raw, pw_raw}};
    sv          = sync_q[SYNC_STAGES-1];
    prev_d      = sv;
    stable      = sv == prev_q;
    commit      = stable && cnt_q == CNT_MAX;
    cnt_d       = !stable ? '0 : commit ? cnt_q : cnt_q + 1'b1;
    dv_d        = commit ? sv : dv_q;
    deb_valid_d = deb_valid_q | commit;
  end

  // Bit 7 of dv is the debounced enter, bits 6:0 the debounced password.
  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    case (state_q)
      ARM_WAIT: if (deb_valid_q) state_d = dv_q[7] ? HELD : IDLE;
      IDLE: if (dv_q[7]) begin
        state_d = FIRE;
        char_d  = dv_q[6:0];
      end
      FIRE:     state_d = HELD;
      HELD:     if (!dv_q[7]) state_d = IDLE;
      default:  state_d = ARM_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      prev_q      <= '0;
      cnt_q       <= '0;
      dv_q        <= '0;
      deb_valid_q <= 1'b0;
      char_q      <= '0;
      state_q     <= ARM_WAIT;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      dv_q        <= dv_d;
      deb_valid_q <= deb_valid_d;
      char_q      <= char_d;
      state_q     <= state_d;
    end
  end

  assign char_out    = char_q;
  assign enter_pulse = state_q == FIRE;
  assign armed       = state_q == IDLE;
endmodule

// File: tb/tb_pw_input_cond.sv
// tb_pw_input_cond: directed scenarios plus random bouncing inputs, checked every
// cycle against a run-length debounce model and debounced-rising-edge press rule.
module tb_pw_input_cond;
  localparam int S = 2;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] pw_raw = '0;
  logic       enter_raw = 1'b0;
  logic [6:0] char_out;
  logic       enter_pulse, armed;

  int n_checks = 0;
  int n_fail = 0;
  int pulses = 0;
  int p0;

  pw_input_cond #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset_n(reset_n), .pw_raw(pw_raw), .enter_raw(enter_raw),
    .char_out(char_out), .enter_pulse(enter_pulse), .armed(armed)
  );

  always #5 clk = ~clk;

  // Reference: raw samples delayed S edges; a value is committed once it has been
  // seen on D+1 consecutive edges. A press fires one edge after the committed enter
  // rises from a previously valid, released state.
  logic [7:0] pipe[$];
  logic [7:0] last_s, dv1, dv2;
  bit         val1, val2;
  int         run;
  logic [6:0] m_char;
  logic       m_pulse, m_armed;

  task automatic model_reset();
    pipe = {};
    repeat (S) pipe.push_back(8'h00);
    last_s = '0; dv1 = '0; dv2 = '0; val1 = 0; val2 = 0; run = 0;
    m_char = '0; m_pulse = 1'b0; m_armed = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] s;
    logic       np, na;
    s = pipe.pop_front();
    pipe.push_back({enter_raw, pw_raw});
    run = (s == last_s) ? run + 1 : 0;
    last_s = s;
    na = val1 && !dv1[7];
    np = val2 && !dv2[7] && dv1[7];
    if (np) m_char = dv1[6:0];
    val2 = val1;
    dv2 = dv1;
    if (run >= D) begin
      dv1 = s;
      val1 = 1;
    end
    m_armed = na;
    m_pulse = np;
  endtask

  always @(posedge clk or negedge reset_n)
    if (!reset_n) model_reset();
    else model_step();

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (enter_pulse === 1'b1) pulses++;
      chk("model_char", {1'b0, char_out}, {1'b0, m_char});
      chk("model_pulse", {7'b0, enter_pulse}, {7'b0, m_pulse});
      chk("model_armed", {7'b0, armed}, {7'b0, m_armed});
    end
  endtask

  initial begin
    model_reset();
    step(3);
    chk("reset_char", {1'b0, char_out}, 8'h00);
    chk("reset_pulse", {7'b0, enter_pulse}, 8'h00);
    chk("reset_armed", {7'b0, armed}, 8'h00);
    reset_n = 1'b1;
    step(19);
    chk("startup_armed", {7'b0, armed}, 8'h01);
    chk("startup_pulses", 8'(pulses), 8'h00);
    chk("startup_char", {1'b0, char_out}, 8'h00);

    pw_raw = 7'h5A;
    step(20);
    enter_raw = 1'b1;
    p0 = pulses;
    step(19);
    chk("press_early", {7'b0, enter_pulse}, 8'h00);
    step(1);
    chk("press_pulse", {7'b0, enter_pulse}, 8'h01);
    chk("press_char", {1'b0, char_out}, 8'h5A);
    step(1);
    chk("press_one_cycle", {7'b0, enter_pulse}, 8'h00);
    step(19);
    chk("press_count", 8'(pulses - p0), 8'h01);
    chk("held_armed", {7'b0, armed}, 8'h00);
    enter_raw = 1'b0;
    step(19);
    chk("release_early", {7'b0, armed}, 8'h00);
    step(1);
    chk("release_armed", {7'b0, armed}, 8'h01);

    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      enter_raw = 1'b1;
      step(5);
      enter_raw = 1'b0;
      step(5);
    end
    chk("bounce_none", 8'(pulses - p0), 8'h00);
    enter_raw = 1'b1;
    step(40);
    chk("bounce_then_hold", 8'(pulses - p0), 8'h01);
    enter_raw = 1'b0;
    step(40);

    pw_raw = 7'h11;
    step(40);
    p0 = pulses;
    pw_raw = 7'h22;
    enter_raw = 1'b1;
    step(40);
    chk("coherent_char", {1'b0, char_out}, 8'h22);
    chk("coherent_count", 8'(pulses - p0), 8'h01);
    enter_raw = 1'b0;
    step(40);

    enter_raw = 1'b1;
    step(5);
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    p0 = pulses;
    step(60);
    chk("held_reset_none", 8'(pulses - p0), 8'h00);
    chk("held_reset_armed", {7'b0, armed}, 8'h00);
    enter_raw = 1'b0;
    step(40);
    chk("held_reset_rearm", {7'b0, armed}, 8'h01);
    pw_raw = 7'h33;
    step(20);
    enter_raw = 1'b1;
    step(40);
    chk("held_reset_press", 8'(pulses - p0), 8'h01);
    chk("held_reset_char", {1'b0, char_out}, 8'h33);
    enter_raw = 1'b0;
    step(40);

    pw_raw = 7'h44;
    enter_raw = 1'b1;
    step(10);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_char", {1'b0, char_out}, 8'h00);
    chk("midreset_pulse", {7'b0, enter_pulse}, 8'h00);
    chk("midreset_armed", {7'b0, armed}, 8'h00);
    step(2);
    reset_n = 1'b1;
    p0 = pulses;
    step(60);
    chk("midreset_none", 8'(pulses - p0), 8'h00);
    chk("midreset_char_hold", {1'b0, char_out}, 8'h00);
    enter_raw = 1'b0;
    step(40);

    for (int i = 0; i < 250; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
      end else begin
        pw_raw = 7'($urandom);
        if (r < 50) enter_raw = ~enter_raw;
        step($urandom_range(1, 40));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
